// File: rtl/saes64_pkg.sv
// Shared types and constants for the SAES64 lockstep checker.
package saes64_pkg;

  localparam int unsigned MAX_LANES = 4;
  localparam int unsigned TIMER_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // Index of the lowest set bit, 0 when none is set.
  function automatic logic [1:0] lowest_set(input logic [MAX_LANES-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = int'(MAX_LANES) - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/saes64_lockstep_checker_if.sv
// Issue/result/status bundle between the redundant SAES64 lanes and the lockstep checker.
interface saes64_lockstep_checker_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CW    = 16
);
  logic                  clr;
  logic                  valid;
  logic [LANES-1:0]      lane_ready;
  logic [LANES*XLEN-1:0] lane_rd;
  logic                  busy;
  logic                  done;
  logic                  agree;
  logic [XLEN-1:0]       rd;
  logic                  mismatch;
  logic                  timeout;
  logic                  proto_err;
  logic [1:0]            err_lane;
  logic [CW-1:0]         op_count;
  logic [CW-1:0]         err_count;

  modport master (
    output clr, valid, lane_ready, lane_rd,
    input  busy, done, agree, rd, mismatch, timeout, proto_err, err_lane, op_count, err_count
  );

  modport slave (
    input  clr, valid, lane_ready, lane_rd,
    output busy, done, agree, rd, mismatch, timeout, proto_err, err_lane, op_count, err_count
  );
endinterface

// File: rtl/saes64_lane_capture.sv
// One lane's result register and capture flag; flags a repeated ready from an already-captured lane.
module saes64_lane_capture #(
  parameter int unsigned XLEN = 64
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            start,
  input  logic            active,
  input  logic            ready,
  input  logic [XLEN-1:0] d,
  output logic            flag_nxt_c,
  output logic [XLEN-1:0] data_nxt_c,
  output logic            dup_c
);

  logic            flag_q;
  logic [XLEN-1:0] data_q;

  // A new issue restarts the capture; later readies only fill an empty slot.
  always_comb begin
    flag_nxt_c = flag_q;
    data_nxt_c = data_q;
    dup_c      = 1'b0;
    if (start) begin
      flag_nxt_c = ready;
      if (ready) data_nxt_c = d;
    end else if (active && ready) begin
      if (flag_q) begin
        dup_c = 1'b1;
      end else begin
        flag_nxt_c = 1'b1;
        data_nxt_c = d;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      flag_q <= 1'b0;
      data_q <= '0;
    end else begin
      flag_q <= flag_nxt_c;
      data_q <= data_nxt_c;
    end
  end

endmodule

// File: rtl/saes64_lockstep_checker.sv
// Lockstep checker: collects LANES redundant SAES64 results, compares them against lane 0,
// and keeps sticky error flags and saturating event counters.
module saes64_lockstep_checker
  import saes64_pkg::*;
#(
  parameter int unsigned LANES       = 2,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned HALT_ON_ERR = 1,
  parameter int unsigned CW          = 16
) (
  input logic                      g_clk,
  input logic                      g_resetn,
  saes64_lockstep_checker_if.slave bus
);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [LANES-1:0]     flag_nxt;
  logic [LANES-1:0]     dup;
  logic [XLEN-1:0]      data_nxt [LANES];
  logic [MAX_LANES-1:0] diff;
  logic                 start, active, chk, all_nxt, tmo_hit;
  logic                 set_mm, set_to, set_pe, ld_err_lane;
  logic                 busy_q, done_q, agree_q, mm_q, to_q, pe_q;
  logic [XLEN-1:0]      rd_q;
  logic [1:0]           err_lane_q;
  logic [CW-1:0]        op_cnt_q, err_cnt_q;

  assign start  = (state_q == ST_IDLE) && bus.valid;
  assign active = (state_q == ST_WAIT);
  assign chk    = (state_q == ST_CHECK);

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    saes64_lane_capture #(.XLEN(XLEN)) u_cap (
      .g_clk      (g_clk),
      .g_resetn   (g_resetn),
      .start      (start),
      .active     (active),
      .ready      (bus.lane_ready[i]),
      .d          (bus.lane_rd[i*XLEN +: XLEN]),
      .flag_nxt_c (flag_nxt[i]),
      .data_nxt_c (data_nxt[i]),
      .dup_c      (dup[i])
    );
  end

  // Per-lane disagreement with lane 0; holds the captured values while in CHECK.
  always_comb begin
    diff = '0;
    for (int i = 1; i < int'(LANES); i++) begin
      diff[i] = (data_nxt[i] != data_nxt[0]);
    end
  end

  assign all_nxt     = &flag_nxt;
  assign tmo_hit     = (timer_q == TIMER_W'(TIMEOUT - 1));
  assign set_mm      = chk && !agree_q;
  assign set_to      = active && !all_nxt && tmo_hit;
  assign set_pe      = |dup;
  assign ld_err_lane = set_mm && (!mm_q || bus.clr);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.valid) state_d = ST_WAIT;
      ST_WAIT: begin
        if (all_nxt)      state_d = ST_CHECK;
        else if (tmo_hit) state_d = ST_ERROR;
      end
      ST_CHECK: state_d = (!agree_q && (HALT_ON_ERR != 0)) ? ST_ERROR : ST_IDLE;
      ST_ERROR: if (bus.clr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (start)       timer_q <= '0;
      else if (active) timer_q <= timer_q + TIMER_W'(1);
    end
  end

  // Result outputs are registered on the edge that enters CHECK so they line up with done.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      agree_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= active && all_nxt;
      if (active && all_nxt) begin
        agree_q <= ~|diff;
        rd_q    <= data_nxt[0];
      end
    end
  end

  // Sticky flags and counters: a set event beats a simultaneous clr.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      mm_q       <= 1'b0;
      to_q       <= 1'b0;
      pe_q       <= 1'b0;
      err_lane_q <= '0;
      op_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (set_mm)       mm_q <= 1'b1;
      else if (bus.clr) mm_q <= 1'b0;
      if (set_to)       to_q <= 1'b1;
      else if (bus.clr) to_q <= 1'b0;
      if (set_pe)       pe_q <= 1'b1;
      else if (bus.clr) pe_q <= 1'b0;
      if (ld_err_lane)  err_lane_q <= lowest_set(diff);
      else if (bus.clr) err_lane_q <= '0;
      if (chk)          op_cnt_q <= bus.clr ? CW'(1) : ((&op_cnt_q) ? op_cnt_q : op_cnt_q + CW'(1));
      else if (bus.clr) op_cnt_q <= '0;
      if (set_mm)       err_cnt_q <= bus.clr ? CW'(1) : ((&err_cnt_q) ? err_cnt_q : err_cnt_q + CW'(1));
      else if (bus.clr) err_cnt_q <= '0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.agree     = agree_q;
  assign bus.rd        = rd_q;
  assign bus.mismatch  = mm_q;
  assign bus.timeout   = to_q;
  assign bus.proto_err = pe_q;
  assign bus.err_lane  = err_lane_q;
  assign bus.op_count  = op_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule
